// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage of the 8-bit RISC pipeline.
// Owns the PC, drives imem_addr combinationally from it, and registers the
// IF/ID packet {fetch_pc, instr}. Resolved next-PC comes in on redirect.
// Optional feature macro: FETCH_BRANCH_HOLD_EN -- when defined, fetch holds
// (WAIT state, bubbles only) after a control-transfer opcode until redirect.
module fetch_unit #(
  parameter logic [7:0]  RESET_PC = 8'h00,
  parameter logic [15:0] NOP_WORD = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [7:0]  redirect_addr,
  output logic [7:0]  imem_addr,
  input  logic [15:0] imem_data,
  output logic [23:0] instruction,
  output logic        valid
);

  logic [7:0]  pc_q, pc_d;
  logic [23:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        hold;

`ifdef FETCH_BRANCH_HOLD_EN
  typedef enum logic {S_RUN, S_WAIT} state_e;
  state_e state_q, state_d;
  logic   is_ctl;

  // br, brz/brn, br.sub and return all resolve in the link/branch unit
  assign is_ctl = imem_data[15:12] inside {4'b1001, 4'b1010, 4'b1011, 4'b1100};
  assign hold   = (state_q == S_WAIT);

  // Next FSM state: enter WAIT on a fetched control transfer, leave only on redirect
  always_comb begin
    state_d = state_q;
    if (redirect) begin
      state_d = S_RUN;
    end else if (!stall && state_q == S_RUN && is_ctl) begin
      state_d = S_WAIT;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RUN;
    end else begin
      state_q <= state_d;
    end
  end
`else
  assign hold = 1'b0;
`endif

  // Next PC / packet: redirect beats stall; held fetch emits bubbles at the held PC
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    if (redirect) begin
      pc_d    = redirect_addr;
      instr_d = {redirect_addr, NOP_WORD};
      valid_d = 1'b0;
    end else if (!stall) begin
      if (hold) begin
        instr_d = {pc_q, NOP_WORD};
        valid_d = 1'b0;
      end else begin
        pc_d    = pc_q + 8'd2;
        instr_d = {pc_q, imem_data};
        valid_d = 1'b1;
      end
    end
  end

  // PC and IF/ID packet registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      instr_q <= {8'h00, NOP_WORD};
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign imem_addr   = pc_q;
  assign instruction = instr_q;
  assign valid       = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit. Stimulus pushes the expected
// post-edge {imem_addr, valid, instruction} tagged with its edge number; a
// negedge monitor pops and compares.
module tb_fetch_unit;

  localparam logic [15:0] NOP = 16'h0F0F;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [7:0]  redirect_addr;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data;
  logic [23:0] instruction;
  logic        valid;

  logic [15:0] mem [256];

  typedef struct {
    int          e;
    string       nm;
    logic [7:0]  a;
    logic        v;
    logic [23:0] ins;
  } exp_t;

  exp_t sb[$];
  exp_t ent;
  int   edge_cnt = 0;
  int   tests    = 0;
  int   failed   = 0;

  fetch_unit #(.RESET_PC(8'h00), .NOP_WORD(NOP)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_addr(redirect_addr),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .instruction  (instruction),
    .valid        (valid)
  );

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr];

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Monitor: compare every expectation whose edge has occurred
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].e <= edge_cnt) begin
      ent = sb.pop_front();
      tests++;
      if (imem_addr !== ent.a || valid !== ent.v || instruction !== ent.ins) begin
        failed++;
        $display("FAIL %s (edge %0d): addr=%h valid=%b instr=%h, expected addr=%h valid=%b instr=%h",
                 ent.nm, ent.e, imem_addr, valid, instruction, ent.a, ent.v, ent.ins);
      end
    end
  end

  // Push expectation for the next rising edge, then advance past it
  task automatic cyc(input string nm, input logic [7:0] a, input logic v, input logic [23:0] ins);
    exp_t x;
    x.e = edge_cnt + 1; x.nm = nm; x.a = a; x.v = v; x.ins = ins;
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic check_now(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, failed + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {4'h3, 8'(i), 4'h0};
    mem[8'h00] = 16'h1234;
    mem[8'h02] = 16'h2345;
    mem[8'h20] = 16'h9040;
    mem[8'h40] = 16'h5A5A;
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_addr = 8'h00;

    // reset held two cycles
    cyc("reset0", 8'h00, 1'b0, 24'h000F0F);
    cyc("reset1", 8'h00, 1'b0, 24'h000F0F);
    rst = 1'b0;
    cyc("fetch00", 8'h02, 1'b1, 24'h001234);
    cyc("fetch02", 8'h04, 1'b1, 24'h022345);
    cyc("fetch04", 8'h06, 1'b1, 24'h043040);
    cyc("fetch06", 8'h08, 1'b1, 24'h063060);
    cyc("fetch08", 8'h0A, 1'b1, 24'h083080);
    cyc("fetch0A", 8'h0C, 1'b1, 24'h0A30A0);
    cyc("fetch0C", 8'h0E, 1'b1, 24'h0C30C0);
    cyc("fetch0E", 8'h10, 1'b1, 24'h0E30E0);

    // stall three edges at PC 10
    stall = 1'b1;
    cyc("stall1", 8'h10, 1'b1, 24'h0E30E0);
    cyc("stall2", 8'h10, 1'b1, 24'h0E30E0);
    cyc("stall3", 8'h10, 1'b1, 24'h0E30E0);
    stall = 1'b0;
    cyc("resume10", 8'h12, 1'b1, 24'h103100);
    cyc("resume12", 8'h14, 1'b1, 24'h123120);

    // redirect wins over stall
    stall = 1'b1; redirect = 1'b1; redirect_addr = 8'h80;
    cyc("redir_stall", 8'h80, 1'b0, 24'h800F0F);
    stall = 1'b0; redirect = 1'b0;
    cyc("fetch80", 8'h82, 1'b1, 24'h803800);

    // wrap FE -> 00
    redirect = 1'b1; redirect_addr = 8'hFE;
    cyc("redirFE", 8'hFE, 1'b0, 24'hFE0F0F);
    redirect = 1'b0;
    cyc("fetchFE", 8'h00, 1'b1, 24'hFE3FE0);
    cyc("wrap00", 8'h02, 1'b1, 24'h001234);

    // odd target is used unaligned
    redirect = 1'b1; redirect_addr = 8'h31;
    cyc("redir31", 8'h31, 1'b0, 24'h310F0F);
    redirect = 1'b0;
    cyc("fetch31", 8'h33, 1'b1, 24'h313310);

    // branch at 20, redirect raised for the very next edge
    redirect = 1'b1; redirect_addr = 8'h20;
    cyc("redir20", 8'h20, 1'b0, 24'h200F0F);
    redirect = 1'b0;
    cyc("br20", 8'h22, 1'b1, 24'h209040);
    redirect = 1'b1; redirect_addr = 8'h40;
    cyc("redir40", 8'h40, 1'b0, 24'h400F0F);
    redirect = 1'b0;
    cyc("fetch40", 8'h42, 1'b1, 24'h405A5A);

    // branch at 20, redirect two edges late
    redirect = 1'b1; redirect_addr = 8'h20;
    cyc("redir20b", 8'h20, 1'b0, 24'h200F0F);
    redirect = 1'b0;
    cyc("br20b", 8'h22, 1'b1, 24'h209040);
`ifdef FETCH_BRANCH_HOLD_EN
    cyc("wait1", 8'h22, 1'b0, 24'h220F0F);
    cyc("wait2", 8'h22, 1'b0, 24'h220F0F);
`else
    cyc("wrongpath22", 8'h24, 1'b1, 24'h223220);
    cyc("wrongpath24", 8'h26, 1'b1, 24'h243240);
`endif
    redirect = 1'b1; redirect_addr = 8'h40;
    cyc("redir40b", 8'h40, 1'b0, 24'h400F0F);
    redirect = 1'b0;
    cyc("fetch40b", 8'h42, 1'b1, 24'h405A5A);

    // asynchronous reset between edges while (possibly) in WAIT
    redirect = 1'b1; redirect_addr = 8'h20;
    cyc("redir20c", 8'h20, 1'b0, 24'h200F0F);
    redirect = 1'b0;
    cyc("br20c", 8'h22, 1'b1, 24'h209040);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_now("async_rst_addr", 32'(imem_addr), 32'h00);
    check_now("async_rst_valid", 32'(valid), 32'h0);
    check_now("async_rst_instr", 32'(instruction), 32'h000F0F);
    cyc("rst_held", 8'h00, 1'b0, 24'h000F0F);
    rst = 1'b0;
    cyc("after_rst00", 8'h02, 1'b1, 24'h001234);
    cyc("after_rst02", 8'h04, 1'b1, 24'h022345);

    @(negedge clk);
    @(negedge clk);
    tests++;
    if (sb.size() != 0) begin
      failed++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
